dsi_lp_escape_receiver: RTL and testbench

- Lane-0 low-power receiver for reverse-direction traffic from the display (read responses, acknowledges, triggers) after bus turnaround.
- Samples the LP line pair and synchronizes/filters it into line states (LP-11/10/01/00).
- Tracks the escape-mode entry sequence and decodes the spaced-one-hot entry command.
- Delivers LPDT bytes, trigger pulses and ULPS status to the packet layer on clk_sys, as the receive-side counterpart of the HS/LP lane transmit path.

---
 rtl/dsi_lp_escape_receiver.sv | 219 +++++++++++++++++++++
 tb/tb_dsi_lp_escape_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_lp_escape_receiver.sv
// DSI lane-0 LP escape-mode receiver: sync/filter the LP pair, decode escape entry,
// command, LPDT bytes, reset trigger and ULPS. Glitch filter enabled by DSI_LP_RX_GLITCH_FILTER_EN.
module dsi_lp_escape_receiver #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       lp_p_in,
    input  logic       lp_n_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_end,
    output logic       trig_reset,
    output logic       ulps_active,
    output logic       err_esc,
    output logic       err_cmd,
    output logic       err_sync
);

    typedef enum logic [3:0] {
        S_IDLE, S_ENT1, S_ENT2, S_ENT3, S_CMD, S_LPDT, S_ULPS, S_ULPS_EXIT, S_WAIT_STOP
    } state_t;

    localparam logic [1:0] LS_11 = 2'b11;
    localparam logic [1:0] LS_10 = 2'b10;
    localparam logic [1:0] LS_01 = 2'b01;
    localparam logic [1:0] LS_00 = 2'b00;

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_bad_cfg
        $error("FILTER_CYCLES must be in 1..15");
    end

    logic [1:0] sync1, sync2, ls, ls_prev;
    logic       ev;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1 <= LS_11;
            sync2 <= LS_11;
        end else begin
            sync1 <= {lp_p_in, lp_n_in};
            sync2 <= sync1;
        end
    end

`ifdef DSI_LP_RX_GLITCH_FILTER_EN
    // A new state is accepted only after FILTER_CYCLES identical samples; any
    // interruption restarts the run from the new candidate.
    logic [1:0] ls_q, cand;
    logic [3:0] flt_cnt, cnt_nxt;

    assign cnt_nxt = (sync2 == cand && flt_cnt != 4'd0) ? flt_cnt + 4'd1 : 4'd1;
    assign ls      = ls_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ls_q    <= LS_11;
            cand    <= LS_11;
            flt_cnt <= 4'd0;
        end else if (sync2 == ls_q) begin
            flt_cnt <= 4'd0;
        end else if (cnt_nxt >= 4'(FILTER_CYCLES)) begin
            ls_q    <= sync2;
            cand    <= sync2;
            flt_cnt <= 4'd0;
        end else begin
            cand    <= sync2;
            flt_cnt <= cnt_nxt;
        end
    end
`else
    assign ls = sync2;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) ls_prev <= LS_11;
        else     ls_prev <= ls;
    end

    assign ev = (ls != ls_prev);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       pend, pend_bit;
    logic [7:0] cmd_word, lsb_word;

    // Word as it will look once the pending bit is committed.
    assign cmd_word = {shreg[6:0], pend_bit};
    assign lsb_word = {pend_bit, shreg[7:1]};

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            pend        <= 1'b0;
            pend_bit    <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_end      <= 1'b0;
            trig_reset  <= 1'b0;
            ulps_active <= 1'b0;
            err_esc     <= 1'b0;
            err_cmd     <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_end     <= 1'b0;
            trig_reset <= 1'b0;
            err_esc    <= 1'b0;
            err_cmd    <= 1'b0;
            err_sync   <= 1'b0;
            if (!rx_en) begin
                state       <= S_IDLE;
                ulps_active <= 1'b0;
                bit_cnt     <= 3'd0;
                shreg       <= 8'd0;
                pend        <= 1'b0;
                pend_bit    <= 1'b0;
            end else if (ev) begin
                case (state)
                    S_IDLE: begin
                        if (ls == LS_10) state <= S_ENT1;
                        else if (ls != LS_11) begin
                            err_esc <= 1'b1;
                            state   <= S_WAIT_STOP;
                        end
                    end
                    S_ENT1, S_ENT2, S_ENT3: begin
                        if (ls == LS_11) begin
                            state <= S_IDLE;
                        end else if (state == S_ENT1 && ls == LS_00) begin
                            state <= S_ENT2;
                        end else if (state == S_ENT2 && ls == LS_01) begin
                            state <= S_ENT3;
                        end else if (state == S_ENT3 && ls == LS_00) begin
                            state   <= S_CMD;
                            bit_cnt <= 3'd0;
                            pend    <= 1'b0;
                        end else begin
                            err_esc <= 1'b1;
                            state   <= S_WAIT_STOP;
                        end
                    end
                    S_CMD, S_LPDT: begin
                        case (ls)
                            LS_00: if (pend) begin
                                pend    <= 1'b0;
                                bit_cnt <= bit_cnt + 3'd1;
                                if (state == S_CMD) begin
                                    shreg <= cmd_word;
                                    if (bit_cnt == 3'd7) begin
                                        case (cmd_word)
                                            8'hE1: state <= S_LPDT;
                                            8'h1E: begin
                                                state       <= S_ULPS;
                                                ulps_active <= 1'b1;
                                            end
                                            8'h62: begin
                                                trig_reset <= 1'b1;
                                                state      <= S_WAIT_STOP;
                                            end
                                            default: begin
                                                err_cmd <= 1'b1;
                                                state   <= S_WAIT_STOP;
                                            end
                                        endcase
                                    end
                                end else begin
                                    shreg <= lsb_word;
                                    if (bit_cnt == 3'd7) begin
                                        rx_data  <= lsb_word;
                                        rx_valid <= 1'b1;
                                    end
                                end
                            end
                            LS_11: begin
                                state <= S_IDLE;
                                pend  <= 1'b0;
                                // Mark-1 followed by stop is the only clean exit.
                                if (state == S_LPDT && pend) begin
                                    if (!pend_bit)             err_esc  <= 1'b1;
                                    else if (bit_cnt == 3'd0)  rx_end   <= 1'b1;
                                    else                       err_sync <= 1'b1;
                                end else if (bit_cnt != 3'd0) begin
                                    err_sync <= 1'b1;
                                end
                            end
                            default: begin
                                if (pend) begin
                                    err_esc <= 1'b1;
                                    pend    <= 1'b0;
                                    state   <= S_WAIT_STOP;
                                end else begin
                                    pend     <= 1'b1;
                                    pend_bit <= (ls == LS_10);
                                end
                            end
                        endcase
                    end
                    S_ULPS: if (ls == LS_10) state <= S_ULPS_EXIT;
                    S_ULPS_EXIT: begin
                        if (ls == LS_11) begin
                            state       <= S_IDLE;
                            ulps_active <= 1'b0;
                        end else if (ls == LS_00) begin
                            state <= S_ULPS;
                        end
                    end
                    S_WAIT_STOP: if (ls == LS_11) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsi_lp_escape_receiver.sv
// Self-checking bench for dsi_lp_escape_receiver: transaction-level expectations
// (bytes sent, commands issued) compared with pulses gathered by a monitor.
module tb_dsi_lp_escape_receiver;
    localparam int FC   = 4;
    localparam int HOLD = 12;

    logic       clk_sys = 1'b0;
    logic       rst, rx_en, lp_p_in, lp_n_in;
    logic [7:0] rx_data;
    logic       rx_valid, rx_end, trig_reset, ulps_active, err_esc, err_cmd, err_sync;

    dsi_lp_escape_receiver #(.FILTER_CYCLES(FC)) dut (
        .clk_sys(clk_sys), .rst(rst), .rx_en(rx_en), .lp_p_in(lp_p_in), .lp_n_in(lp_n_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_end(rx_end), .trig_reset(trig_reset),
        .ulps_active(ulps_active), .err_esc(err_esc), .err_cmd(err_cmd), .err_sync(err_sync)
    );

    always #5 clk_sys = ~clk_sys;

    int passed = 0, total = 0;
    int n_end, n_trig, n_eesc, n_ecmd, n_esync, n_wide = 0, n_overlap = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [5:0] prev_pul = '0;

    // Monitor: gather pulses away from the active edge.
    always @(negedge clk_sys) begin
        logic [5:0] pul;
        pul = {rx_valid, rx_end, trig_reset, err_esc, err_cmd, err_sync};
        if (rx_valid)   got_q.push_back(rx_data);
        if (rx_end)     n_end++;
        if (trig_reset) n_trig++;
        if (err_esc)    n_eesc++;
        if (err_cmd)    n_ecmd++;
        if (err_sync)   n_esync++;
        if (rx_valid && rx_end) n_overlap++;
        if (|(pul & prev_pul))  n_wide++;
        prev_pul = pul;
    end

    task automatic clear_mon();
        n_end = 0; n_trig = 0; n_eesc = 0; n_ecmd = 0; n_esync = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive(input logic [1:0] s);
        {lp_p_in, lp_n_in} = s;
        repeat (HOLD) @(posedge clk_sys);
    endtask

    task automatic send_entry();
        drive(2'b10); drive(2'b00); drive(2'b01); drive(2'b00);
    endtask

    task automatic send_bit(input logic b);
        drive(b ? 2'b10 : 2'b01);
        drive(2'b00);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_exit();
        drive(2'b10); drive(2'b11);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_en = 1'b1; lp_p_in = 1'b1; lp_n_in = 1'b1;
        repeat (4) @(posedge clk_sys);
        @(negedge clk_sys);
        total++;
        if ({rx_data, rx_valid, rx_end, trig_reset, ulps_active, err_esc, err_cmd, err_sync} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_data, rx_valid, rx_end, trig_reset, ulps_active, err_esc, err_cmd, err_sync});
        else passed++;
        rst = 1'b0;
        repeat (HOLD) @(posedge clk_sys);
        clear_mon();
    endtask

    task automatic test_lpdt_directed();
        clear_mon();
        send_entry(); send_cmd(8'hE1); send_byte(8'hA5); send_exit();
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (got_q.size() !== 1) $display("FAIL a5_count: got %0d expected 1", got_q.size());
        else passed++;
        total++;
        if (got_q.size() < 1 || got_q[0] !== 8'hA5) $display("FAIL a5_data: got %h expected a5", rx_data);
        else passed++;
        total++;
        if (n_end !== 1) $display("FAIL a5_end: got %0d expected 1", n_end); else passed++;
        total++;
        if (n_eesc + n_ecmd + n_esync + n_trig !== 0)
            $display("FAIL a5_errs: got %0d expected 0", n_eesc + n_ecmd + n_esync + n_trig);
        else passed++;
        total++;
        if (rx_data !== 8'hA5) $display("FAIL a5_hold: got %h expected a5", rx_data); else passed++;
    endtask

    task automatic test_lpdt_random();
        int bad = 0;
        clear_mon();
        for (int f = 0; f < 5; f++) begin
            int nb = $urandom_range(1, 3);
            send_entry(); send_cmd(8'hE1);
            for (int b = 0; b < nb; b++) begin
                logic [7:0] d = 8'($urandom);
                exp_q.push_back(d);
                send_byte(d);
            end
            send_exit();
        end
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else begin
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
            if (bad != 0) $display("FAIL rand_data: got %0d wrong bytes expected 0", bad);
            else passed++;
        end
        total++;
        if (n_end !== 5) $display("FAIL rand_end: got %0d expected 5", n_end); else passed++;
        total++;
        if (n_eesc + n_ecmd + n_esync !== 0)
            $display("FAIL rand_errs: got %0d expected 0", n_eesc + n_ecmd + n_esync);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        clear_mon();
        send_entry(); send_cmd(8'hE1);
        for (int b = 0; b < 6; b++) begin
            logic [7:0] d = 8'($urandom);
            exp_q.push_back(d);
            send_byte(d);
        end
        send_exit();
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (got_q.size() !== 6) $display("FAIL b2b_count: got %0d expected 6", got_q.size());
        else begin
            foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
            if (bad != 0) $display("FAIL b2b_data: got %0d wrong bytes expected 0", bad);
            else passed++;
        end
        total++;
        if (rx_data !== exp_q[5]) $display("FAIL b2b_hold: got %h expected %h", rx_data, exp_q[5]);
        else passed++;
    endtask

    task automatic test_trigger();
        clear_mon();
        send_entry(); send_cmd(8'h62); drive(2'b11);
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (n_trig !== 1) $display("FAIL trig_count: got %0d expected 1", n_trig); else passed++;
        total++;
        if (n_eesc + n_ecmd + n_esync + got_q.size() !== 0)
            $display("FAIL trig_side: got %0d expected 0", n_eesc + n_ecmd + n_esync + got_q.size());
        else passed++;
    endtask

    task automatic test_ulps();
        clear_mon();
        send_entry(); send_cmd(8'h1E);
        total++;
        if (ulps_active !== 1'b1) $display("FAIL ulps_on: got %b expected 1", ulps_active); else passed++;
        drive(2'b10); drive(2'b00); drive(2'b10);
        total++;
        if (ulps_active !== 1'b1) $display("FAIL ulps_mark: got %b expected 1", ulps_active); else passed++;
        drive(2'b11);
        total++;
        if (ulps_active !== 1'b0) $display("FAIL ulps_off: got %b expected 0", ulps_active); else passed++;
        total++;
        if (n_eesc + n_ecmd + n_esync !== 0)
            $display("FAIL ulps_errs: got %0d expected 0", n_eesc + n_ecmd + n_esync);
        else passed++;
    endtask

    task automatic test_err_cmd();
        logic [7:0] c;
        clear_mon();
        do c = 8'($urandom); while (c == 8'hE1 || c == 8'h1E || c == 8'h62);
        send_entry(); send_cmd(c); drive(2'b11);
        total++;
        if (n_ecmd !== 1) $display("FAIL cmd_err: got %0d expected 1 (cmd %h)", n_ecmd, c); else passed++;
        total++;
        if (n_trig + n_eesc + n_esync + int'(ulps_active) !== 0)
            $display("FAIL cmd_side: got %0d expected 0", n_trig + n_eesc + n_esync + int'(ulps_active));
        else passed++;
    endtask

    task automatic test_err_sync();
        clear_mon();
        send_entry(); send_cmd(8'hE1);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        send_exit();
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (n_esync !== 1) $display("FAIL sync_err: got %0d expected 1", n_esync); else passed++;
        total++;
        if (n_end + got_q.size() + n_eesc !== 0)
            $display("FAIL sync_side: got %0d expected 0", n_end + got_q.size() + n_eesc);
        else passed++;
    endtask

    task automatic test_err_esc();
        clear_mon();
        drive(2'b10); drive(2'b01);
        drive(2'b00); drive(2'b10); drive(2'b00);
        total++;
        if (n_eesc !== 1) $display("FAIL esc_entry: got %0d expected 1", n_eesc); else passed++;
        drive(2'b11);
        // Mark-0 followed by stop is not a valid exit.
        send_entry(); send_cmd(8'hE1); send_byte(8'h3C); drive(2'b01); drive(2'b11);
        total++;
        if (n_eesc !== 2 || n_end !== 0)
            $display("FAIL esc_mark0: got esc=%0d end=%0d expected esc=2 end=0", n_eesc, n_end);
        else passed++;
        // Mark-to-mark.
        send_entry(); send_cmd(8'hE1); drive(2'b10); drive(2'b01); drive(2'b11);
        total++;
        if (n_eesc !== 3 || n_ecmd + n_esync !== 0)
            $display("FAIL esc_m2m: got esc=%0d other=%0d expected 3/0", n_eesc, n_ecmd + n_esync);
        else passed++;
    endtask

    task automatic test_rx_en();
        clear_mon();
        send_entry(); send_cmd(8'hE1); send_bit(1'b1); send_bit(1'b0); drive(2'b10);
        rx_en = 1'b0;
        drive(2'b00); drive(2'b11);
        rx_en = 1'b1;
        repeat (HOLD) @(posedge clk_sys);
        send_entry(); send_cmd(8'h1E);
        rx_en = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        total++;
        if (ulps_active !== 1'b0) $display("FAIL en_ulps: got %b expected 0", ulps_active); else passed++;
        drive(2'b11);
        rx_en = 1'b1;
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (n_eesc + n_ecmd + n_esync + n_end + got_q.size() !== 0)
            $display("FAIL en_quiet: got %0d expected 0", n_eesc + n_ecmd + n_esync + n_end + got_q.size());
        else passed++;
        send_entry(); send_cmd(8'hE1); send_byte(8'h5A); send_exit();
        total++;
        if (got_q.size() !== 1 || n_end !== 1)
            $display("FAIL en_recover: got bytes=%0d end=%0d expected 1/1", got_q.size(), n_end);
        else passed++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_entry(); send_cmd(8'hE1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        #2 rst = 1'b1;
        {lp_p_in, lp_n_in} = 2'b11;
        @(negedge clk_sys);
        total++;
        if ({rx_data, rx_valid, rx_end, ulps_active, err_esc, err_cmd, err_sync} !== 14'd0)
            $display("FAIL rst_byte: got %h expected 0",
                     {rx_data, rx_valid, rx_end, ulps_active, err_esc, err_cmd, err_sync});
        else passed++;
        repeat (4) @(posedge clk_sys);
        rst = 1'b0;
        repeat (HOLD) @(posedge clk_sys);
        send_entry(); send_cmd(8'h1E);
        #2 rst = 1'b1;
        {lp_p_in, lp_n_in} = 2'b11;
        @(negedge clk_sys);
        total++;
        if (ulps_active !== 1'b0) $display("FAIL rst_ulps: got %b expected 0", ulps_active); else passed++;
        repeat (4) @(posedge clk_sys);
        rst = 1'b0;
        repeat (HOLD) @(posedge clk_sys);
        total++;
        if (n_eesc + n_ecmd + n_esync !== 0)
            $display("FAIL rst_errs: got %0d expected 0", n_eesc + n_ecmd + n_esync);
        else passed++;
    endtask

    task automatic test_glitch();
        clear_mon();
        {lp_p_in, lp_n_in} = 2'b01;
        repeat (2) @(posedge clk_sys);
        {lp_p_in, lp_n_in} = 2'b11;
        repeat (HOLD) @(posedge clk_sys);
        total++;
`ifdef DSI_LP_RX_GLITCH_FILTER_EN
        if (n_eesc !== 0) $display("FAIL glitch_filtered: got %0d expected 0", n_eesc); else passed++;
`else
        if (n_eesc !== 1) $display("FAIL glitch_unfiltered: got %0d expected 1", n_eesc); else passed++;
`endif
        send_entry(); send_cmd(8'hE1); send_byte(8'hC3); send_exit();
        total++;
        if (got_q.size() !== 1 || got_q[0] !== 8'hC3)
            $display("FAIL glitch_after: got %0d bytes expected 1 (c3)", got_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lpdt_directed();
        test_lpdt_random();
        test_back_to_back();
        test_trigger();
        test_ulps();
        test_err_cmd();
        test_err_sync();
        test_err_esc();
        test_rx_en();
        test_reset_mid();
        test_glitch();
        total++;
        if (n_wide !== 0 || n_overlap !== 0)
            $display("FAIL pulse_shape: got wide=%0d overlap=%0d expected 0/0", n_wide, n_overlap);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
